// File: rtl/kyber_pke_enc_core_pkg.sv
// Shared constants, encodings, state enum and the Kyber compression helper.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package kyber_pkg;
    localparam int Q          = 3329;
    localparam int N          = 256;
    localparam int R_LEN      = 32;
    localparam int M_LEN      = 32;
    localparam int E_LEN      = 32;
    localparam int RHO_LEN    = 32;
    localparam int POLY_BYTES = 384;

    typedef enum logic [3:0] {
        IT_NONE = 4'd0,
        IT_R    = 4'd1,
        IT_T    = 4'd2,
        IT_M    = 4'd3,
        IT_E    = 4'd4
    } itype_e;

    typedef enum logic [2:0] {
        S_IDLE, S_LD_R, S_LD_T, S_LD_M, S_LD_E, S_COMP, S_OUT, S_DONE
    } state_e;

    // Single conditional subtraction; callers guarantee x < 2q.
    function automatic logic [11:0] mod_q(input logic [12:0] x);
        return (x >= 13'(Q)) ? 12'(x - 13'(Q)) : x[11:0];
    endfunction

    // Compress_d(x) = floor((x*2^d + 1664) / q) mod 2^d, exact integer math.
    function automatic logic [11:0] compress(input logic [11:0] x, input int unsigned d);
        logic [23:0] num;
        logic [23:0] quo;
        num = (24'(x) << d) + 24'd1664;
        quo = num / 24'(Q);
        return quo[11:0] & ((12'd1 << d) - 12'd1);
    endfunction
endpackage

// File: rtl/kyber_pke_enc_core_if.sv
// Host-side byte load / ciphertext pair read bundle for the PKE encrypt core.
// Latency: n/a (wiring only).
// Backpressure: readin_ok gates bytes in; readout paces pairs out.
interface kyber_pke_enc_core_if;
    logic        set;
    logic        readin;
    logic        readout;
    logic        full_in;
    logic [3:0]  data_type;
    logic [7:0]  kyber_din;
    logic [15:0] kyber_in_index;
    logic [3:0]  input_type;
    logic        readin_ok;
    logic [15:0] kyber_dout_1;
    logic [15:0] kyber_dout_2;
    logic [15:0] kyber_out_index;
    logic        done;

    modport master (
        output set, readin, readout, full_in, data_type, kyber_din, kyber_in_index,
        input  input_type, readin_ok, kyber_dout_1, kyber_dout_2, kyber_out_index, done
    );
    modport slave (
        input  set, readin, readout, full_in, data_type, kyber_din, kyber_in_index,
        output input_type, readin_ok, kyber_dout_1, kyber_dout_2, kyber_out_index, done
    );
endinterface

// File: rtl/kyber_pke_enc_core_compress.sv
// Combinational Compress_D of one coefficient already reduced mod q.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module kyber_compress
    import kyber_pkg::*;
#(
    parameter int D = 10
) (
    input  logic [11:0]  x,
    output logic [D-1:0] y
);
    assign y = D'(compress(x, D));
endmodule

// File: rtl/kyber_pke_enc_core.sv
// Kyber PKE encrypt front end: byte loader, per-coefficient compress, packed pair output.
// Latency: one coefficient per cycle in COMP ((K+1)*256 cycles), outputs combinational in OUT.
// Backpressure: bytes accepted every LD cycle; pairs held until readout; KYBER_PKE_ENC_BOUNDS_EN drops out-of-range writes.
module kyber_pke_enc_core
    import kyber_pkg::*;
#(
    parameter int K  = 3,
    parameter int DU = 10,
    parameter int DV = 4
) (
    input  logic               clk,
    input  logic               reset,
    kyber_pke_enc_core_if.slave bus
);
    localparam int T_KEY   = POLY_BYTES * K;
    localparam int T_LEN   = T_KEY + RHO_LEN;
    localparam int TAW     = $clog2(T_KEY);
    localparam int U_COEF  = K * N;
    localparam int NCOEF   = (K + 1) * N;
    localparam int CW      = $clog2(NCOEF);
    localparam int CT_BITS = N * (DU * K + DV);
    localparam int P_PAIRS = CT_BITS / 32;
    localparam int CTW     = $clog2(CT_BITS);

    state_e             state, state_nxt;
    itype_e             itype;
    logic [7:0]         r_mem [R_LEN];
    logic [7:0]         t_mem [T_KEY];
    logic [7:0]         m_mem [M_LEN];
    logic [7:0]         e_mem [E_LEN];
    logic [CT_BITS-1:0] ct;
    logic [CW-1:0]      cnt;
    logic [15:0]        out_idx;
    logic [15:0]        t_lin;
    logic               in_range;
    logic               wr_en;
    logic [4:0]         b_a;

`ifdef KYBER_PKE_ENC_BOUNDS_EN
    logic [15:0] phase_len;
    // Length of the phase being loaded; anything at or past it is dropped.
    always_comb begin
        phase_len = '0;
        case (state)
            S_LD_R:  phase_len = 16'(R_LEN);
            S_LD_T:  phase_len = 16'(T_LEN);
            S_LD_M:  phase_len = 16'(M_LEN);
            S_LD_E:  phase_len = 16'(E_LEN);
            default: phase_len = '0;
        endcase
    end
    assign t_lin    = bus.kyber_in_index;
    assign in_range = bus.kyber_in_index < phase_len;
`else
    assign t_lin    = bus.kyber_in_index % 16'(T_LEN);
    assign in_range = 1'b1;
`endif

    // Next state and phase request; dropping set aborts from anywhere but IDLE.
    always_comb begin
        state_nxt = state;
        itype     = IT_NONE;
        case (state)
            S_IDLE: if (bus.set) state_nxt = S_LD_R;
            S_LD_R: begin itype = IT_R; if (bus.full_in) state_nxt = S_LD_T; end
            S_LD_T: begin itype = IT_T; if (bus.full_in) state_nxt = S_LD_M; end
            S_LD_M: begin itype = IT_M; if (bus.full_in) state_nxt = S_LD_E; end
            S_LD_E: begin itype = IT_E; if (bus.full_in) state_nxt = S_COMP; end
            S_COMP: if (cnt == CW'(NCOEF - 1)) state_nxt = S_OUT;
            S_OUT:  if (bus.readout && out_idx == 16'(P_PAIRS - 1)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (state != S_IDLE && !bus.set) state_nxt = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    assign wr_en = bus.readin && (itype != IT_NONE) && (bus.data_type == itype) && in_range;
    assign b_a   = bus.kyber_in_index[4:0];

    // Byte storage; rho bytes of the public key fall past T_KEY and are discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < R_LEN; i++) begin
                r_mem[i] <= '0;
                m_mem[i] <= '0;
                e_mem[i] <= '0;
            end
            for (int i = 0; i < T_KEY; i++) t_mem[i] <= '0;
        end else if (wr_en) begin
            case (state)
                S_LD_R:  r_mem[b_a] <= bus.kyber_din;
                S_LD_T:  if (t_lin < 16'(T_KEY)) t_mem[t_lin[TAW-1:0]] <= bus.kyber_din;
                S_LD_M:  m_mem[b_a] <= bus.kyber_din;
                S_LD_E:  e_mem[b_a] <= bus.kyber_din;
                default: ;
            endcase
        end
    end

    // Coefficient datapath: cnt walks all u coefficients, then the v polynomial.
    logic            is_v;
    logic [CW-1:0]   ucnt;
    logic [TAW-1:0]  tb0;
    logic [7:0]      b0, b1, b2;
    logic [11:0]     t_raw, t_coef, u_in, v_in;
    logic            m_bit;
    logic [DU-1:0]   u_c;
    logic [DV-1:0]   v_c;
    logic [CTW-1:0]  off_u, off_v, off_o;
    logic [31:0]     pair;

    assign is_v   = cnt >= CW'(U_COEF);
    assign ucnt   = is_v ? '0 : cnt;
    assign tb0    = TAW'(32'(ucnt >> 1) * 32'd3);
    assign b0     = t_mem[tb0];
    assign b1     = t_mem[tb0 + TAW'(1)];
    assign b2     = t_mem[tb0 + TAW'(2)];
    assign t_raw  = ucnt[0] ? {b2, b1[7:4]} : {b1[3:0], b0};
    assign t_coef = mod_q({1'b0, t_raw});
    assign u_in   = mod_q(13'(t_coef) + 13'(r_mem[cnt[4:0]]));
    assign m_bit  = m_mem[cnt[7:3]][cnt[2:0]];
    assign v_in   = mod_q((m_bit ? 13'd1665 : 13'd0) + 13'(e_mem[cnt[4:0]]));
    assign off_u  = CTW'(32'(cnt) * DU);
    assign off_v  = CTW'(U_COEF * DU + (32'(cnt) - U_COEF) * DV);

    kyber_compress #(.D(DU)) u_cmp (.x(u_in), .y(u_c));
    kyber_compress #(.D(DV)) v_cmp (.x(v_in), .y(v_c));

    // Coefficient counter during COMP and pair index during OUT (held in DONE).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            out_idx <= '0;
        end else begin
            cnt <= (state == S_COMP) ? cnt + CW'(1) : '0;
            if (state == S_OUT) begin
                if (bus.readout && out_idx != 16'(P_PAIRS - 1)) out_idx <= out_idx + 16'd1;
            end else if (state != S_DONE) begin
                out_idx <= '0;
            end
        end
    end

    // Pack each compressed coefficient at its bit offset; the stream is fully rewritten every COMP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ct <= '0;
        end else if (state == S_COMP) begin
            if (is_v) ct[off_v +: DV] <= v_c;
            else      ct[off_u +: DU] <= u_c;
        end
    end

    assign off_o = CTW'({out_idx, 5'd0});
    assign pair  = ct[off_o +: 32];

    assign bus.input_type      = itype;
    assign bus.readin_ok       = (itype != IT_NONE);
    assign bus.done            = (state == S_DONE);
    assign bus.kyber_out_index = out_idx;
    assign bus.kyber_dout_1    = (state == S_OUT || state == S_DONE) ? pair[15:0]  : 16'd0;
    assign bus.kyber_dout_2    = (state == S_OUT || state == S_DONE) ? pair[31:16] : 16'd0;
endmodule

// File: tb/tb_kyber_pke_enc_core.sv
// Directed/randomized bench for kyber_pke_enc_core against a bitstream-level reference model.
// Latency: waits a fixed 4100 cycles for COMP before reading pairs.
// Backpressure: drives readout every cycle while reading.
module tb_kyber_pke_enc_core;
    localparam int P  = 272;
    localparam int W  = 544;
    localparam int NB = 8704;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    kyber_pke_enc_core_if bus();
    kyber_pke_enc_core dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int r_m [32];
    int t_m [1184];
    int m_m [32];
    int e_m [32];
    int exp_w [W];
    logic [15:0] first_lo;
    logic [15:0] last_hi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int compress_ref(input int x, input int d);
        return (((x << d) + 1664) / 3329) % (1 << d);
    endfunction

    // Reference: decode t, add r / message bits and e, compress, emit an LSB-first bitstream, then bytes, then words.
    task automatic build_model();
        bit bs [NB];
        int by [NB/8];
        int pos = 0;
        int c, x, g, j, mb;
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 256; n++) begin
                g = i * 256 + n;
                j = g / 2;
                if (g % 2 == 0) c = t_m[3*j] | ((t_m[3*j+1] & 15) << 8);
                else            c = (t_m[3*j+1] >> 4) | (t_m[3*j+2] << 4);
                if (c >= 3329) c = c - 3329;
                x = (c + r_m[n % 32]) % 3329;
                c = compress_ref(x, 10);
                for (int b = 0; b < 10; b++) begin bs[pos] = bit'((c >> b) & 1); pos++; end
            end
        end
        for (int n = 0; n < 256; n++) begin
            mb = (m_m[n / 8] >> (n % 8)) & 1;
            x  = (1665 * mb + e_m[n % 32]) % 3329;
            c  = compress_ref(x, 4);
            for (int b = 0; b < 4; b++) begin bs[pos] = bit'((c >> b) & 1); pos++; end
        end
        for (int k = 0; k < NB / 8; k++) begin
            by[k] = 0;
            for (int b = 0; b < 8; b++) by[k] = by[k] | (int'(bs[8*k+b]) << b);
        end
        for (int w = 0; w < W; w++) exp_w[w] = by[2*w] | (by[2*w+1] << 8);
    endtask

    // Fill the model arrays; -1 selects random bytes.
    task automatic fill(input int rv, input int tv, input int mv, input int ev);
        for (int i = 0; i < 32; i++) begin
            r_m[i] = (rv < 0) ? int'($urandom_range(0, 255)) : rv;
            m_m[i] = (mv < 0) ? int'($urandom_range(0, 255)) : mv;
            e_m[i] = (ev < 0) ? int'($urandom_range(0, 255)) : ev;
        end
        for (int i = 0; i < 1184; i++) t_m[i] = (tv < 0) ? int'($urandom_range(0, 255)) : tv;
    endtask

    task automatic wr(input int typ, input int idx, input int val, input bit last);
        bus.readin         = 1'b1;
        bus.data_type      = 4'(typ);
        bus.kyber_in_index = 16'(idx);
        bus.kyber_din      = 8'(val);
        bus.full_in        = last;
        @(negedge clk);
        bus.readin  = 1'b0;
        bus.full_in = 1'b0;
    endtask

    task automatic phase(input int typ, input int nb);
        int val;
        chk($sformatf("input_type_%0d", typ), 32'(bus.input_type), 32'(typ));
        chk($sformatf("readin_ok_%0d", typ), 32'(bus.readin_ok), 32'd1);
        if (nb == 0) begin
            bus.full_in = 1'b1;
            @(negedge clk);
            bus.full_in = 1'b0;
        end else begin
            for (int i = 0; i < nb; i++) begin
                case (typ)
                    1:       val = r_m[i];
                    2:       val = t_m[i];
                    3:       val = m_m[i];
                    default: val = e_m[i];
                endcase
                wr(typ, i, val, i == nb - 1);
            end
        end
    endtask

    task automatic start_run();
        bus.set = 1'b1;
        @(negedge clk);
        phase(1, 32);
        phase(2, 1184);
        phase(3, 32);
        phase(4, 32);
    endtask

    task automatic wait_comp(input string nm);
        repeat (4100) @(negedge clk);
        chk({nm, "_comp_type"}, 32'(bus.input_type), 32'd0);
        chk({nm, "_comp_done"}, 32'(bus.done), 32'd0);
    endtask

    task automatic read_pairs(input string nm, input int cnt);
        for (int p = 0; p < cnt; p++) begin
            chk($sformatf("%s_idx_%0d", nm, p), 32'(bus.kyber_out_index), 32'(p));
            chk($sformatf("%s_d1_%0d", nm, p), 32'(bus.kyber_dout_1), 32'(exp_w[2*p] & 16'hFFFF));
            chk($sformatf("%s_d2_%0d", nm, p), 32'(bus.kyber_dout_2), 32'(exp_w[2*p+1] & 16'hFFFF));
            if (p == 0)     first_lo = bus.kyber_dout_1;
            if (p == P - 1) last_hi  = bus.kyber_dout_2;
            bus.readout = 1'b1;
            @(negedge clk);
        end
        bus.readout = 1'b0;
    endtask

    task automatic finish_run(input string nm);
        chk({nm, "_done"}, 32'(bus.done), 32'd1);
        chk({nm, "_done_idx"}, 32'(bus.kyber_out_index), 32'(P - 1));
        chk({nm, "_done_hold"}, 32'(bus.kyber_dout_1), 32'(exp_w[W-2] & 16'hFFFF));
        bus.set = 1'b0;
        @(negedge clk);
        chk({nm, "_done_clr"}, 32'(bus.done), 32'd0);
        chk({nm, "_idle_type"}, 32'(bus.input_type), 32'd0);
    endtask

    task automatic full_run(input string nm);
        build_model();
        start_run();
        wait_comp(nm);
        read_pairs(nm, P);
        finish_run(nm);
    endtask

    initial begin
        bus.set = 1'b0; bus.readin = 1'b0; bus.readout = 1'b0; bus.full_in = 1'b0;
        bus.data_type = 4'd0; bus.kyber_din = 8'd0; bus.kyber_in_index = 16'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_type", 32'(bus.input_type), 32'd0);
        chk("rst_ok",   32'(bus.readin_ok), 32'd0);
        chk("rst_d1",   32'(bus.kyber_dout_1), 32'd0);
        chk("rst_d2",   32'(bus.kyber_dout_2), 32'd0);
        chk("rst_idx",  32'(bus.kyber_out_index), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // All-zero inputs
        fill(0, 0, 0, 0);
        full_run("zero");

        // Message all ones: every v coefficient compresses to 8
        fill(0, 0, 255, 0);
        full_run("m_ff");
        chk("m_ff_last_pair_hi", 32'(last_hi), 32'h8888);

        // Public key bytes all 0xFF: coefficient 4095 -> 766 -> u 236
        fill(0, 255, 0, 0);
        full_run("t_ff");
        chk("t_ff_word0", 32'(first_lo), 32'hB0EC);

        // Fully random
        fill(-1, -1, -1, -1);
        full_run("rand");

        // Reset clears storage; short r phase, ignored wrong-type byte, out-of-range index
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        fill(0, 0, 0, 0);
        bus.set = 1'b1;
        @(negedge clk);
        chk("short_type_r", 32'(bus.input_type), 32'd1);
        wr(3, 10, 8'hAB, 1'b0);
        wr(1, 37, 8'h5A, 1'b0);
`ifndef KYBER_PKE_ENC_BOUNDS_EN
        r_m[5] = 8'h5A;
`endif
        for (int i = 0; i < 4; i++) r_m[i] = int'($urandom_range(1, 255));
        for (int i = 0; i < 4; i++) wr(1, i, r_m[i], i == 3);
        phase(2, 0);
        phase(3, 0);
        phase(4, 0);
        build_model();
        wait_comp("short");
        read_pairs("short", P);
        finish_run("short");

        // Asynchronous reset in the middle of OUT, then restart
        fill(-1, -1, -1, -1);
        build_model();
        start_run();
        wait_comp("arst");
        read_pairs("arst", 5);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_type", 32'(bus.input_type), 32'd0);
        chk("arst_d1",   32'(bus.kyber_dout_1), 32'd0);
        chk("arst_d2",   32'(bus.kyber_dout_2), 32'd0);
        chk("arst_idx",  32'(bus.kyber_out_index), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("restart_type", 32'(bus.input_type), 32'd1);
        bus.set = 1'b0;
        @(negedge clk);
        chk("abort_type", 32'(bus.input_type), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
